// File: rtl/median_filter_nch_pkg.sv
// Shared types and constants for the N-channel 3x3 median filter.
package median_filter_nch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Window register plus median register.
    localparam int PIPE_LAT = 2;

endpackage

// File: rtl/median9.sv
// Combinational 9-input median: 19 compare-exchange stages, result is the
// 5th-smallest sample (unsigned, duplicates counted).
module median9 #(
    parameter int PIX_W = 8
) (
    input  logic [8:0][PIX_W-1:0] samples,
    output logic [PIX_W-1:0]      med
);

    localparam int NCX = 19;
    // Each pair leaves the lower value at index A and the higher at index B.
    localparam int PA [NCX] = '{1, 4, 7, 0, 3, 6, 1, 4, 7, 0, 5, 4, 3, 1, 2, 4, 4, 6, 4};
    localparam int PB [NCX] = '{2, 5, 8, 1, 4, 7, 2, 5, 8, 3, 8, 7, 6, 4, 5, 7, 2, 4, 2};

    logic [8:0][PIX_W-1:0] stg [NCX+1];

    assign stg[0] = samples;

    for (genvar i = 0; i < NCX; i++) begin : g_cx
        always_comb begin
            stg[i+1] = stg[i];
            if (stg[i][PA[i]] > stg[i][PB[i]]) begin
                stg[i+1][PA[i]] = stg[i][PB[i]];
                stg[i+1][PB[i]] = stg[i][PA[i]];
            end
        end
    end

    assign med = stg[NCX][4];

endmodule

// File: rtl/median_filter_nch.sv
// Raster-scan 3x3 per-channel median filter with two internal line buffers.
// Optional pass-through mode is built when MEDIAN_FILTER_NCH_BYPASS_EN is defined.
module median_filter_nch
    import median_filter_nch_pkg::*;
#(
    parameter int IMAGE_LEN    = 1080,
    parameter int IMAGE_HEIGHT = 720,
    parameter int CHANNELS     = 3,
    parameter int PIX_W        = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
`ifdef MEDIAN_FILTER_NCH_BYPASS_EN
    input  logic                      bypass_i,
`endif
    input  logic                      valid_i,
    input  logic [CHANNELS*PIX_W-1:0] data_i,
    output logic                      done_o,
    output logic                      valid_o,
    output logic [CHANNELS*PIX_W-1:0] data_o
);

    localparam int DW  = CHANNELS * PIX_W;
    localparam int CW  = $clog2(IMAGE_LEN);
    localparam int RW  = $clog2(IMAGE_HEIGHT);
    localparam int DCW = $clog2(PIPE_LAT);

    typedef logic [DW-1:0] pixel_t;

    state_t          state;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [DCW-1:0]  drain_cnt;
    logic            bypass;

    pixel_t          line0 [IMAGE_LEN];
    pixel_t          line1 [IMAGE_LEN];
    pixel_t          tap0, tap1;
    pixel_t          win [3][3];
    pixel_t          med;

    logic [PIPE_LAT:1] vld_pipe;
    logic            accept, last_col, last_pix, win_ok;

    assign accept   = (state == RUN) && valid_i;
    assign last_col = (col == CW'(IMAGE_LEN - 1));
    assign last_pix = last_col && (row == RW'(IMAGE_HEIGHT - 1));
    // Border windows (first two rows/cols) never reach the output.
    assign win_ok   = accept && (bypass || ((row >= RW'(2)) && (col >= CW'(2))));

    assign tap0 = line0[col];
    assign tap1 = line1[col];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            drain_cnt <= '0;
            done_o    <= 1'b0;
`ifdef MEDIAN_FILTER_NCH_BYPASS_EN
            bypass    <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state <= RUN;
                        col   <= '0;
                        row   <= '0;
`ifdef MEDIAN_FILTER_NCH_BYPASS_EN
                        bypass <= bypass_i;
`endif
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_pix) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                        if (last_col) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DCW'(PIPE_LAT - 1)) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifndef MEDIAN_FILTER_NCH_BYPASS_EN
    assign bypass = 1'b0;
`endif

    // Line buffers and window hold pure data; their reset value is irrelevant.
    always_ff @(posedge clk) begin
        if (accept) begin
            line1[col] <= tap0;
            line0[col] <= data_i;
            for (int c = 2; c > 0; c--) begin
                for (int r = 0; r < 3; r++) begin
                    win[c][r] <= win[c-1][r];
                end
            end
            win[0][0] <= tap1;
            win[0][1] <= tap0;
            win[0][2] <= data_i;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [8:0][PIX_W-1:0] samples;
        for (genvar c = 0; c < 3; c++) begin : g_c
            for (genvar r = 0; r < 3; r++) begin : g_r
                assign samples[c*3 + r] = win[c][r][k*PIX_W +: PIX_W];
            end
        end
        median9 #(.PIX_W(PIX_W)) u_med (
            .samples (samples),
            .med     (med[k*PIX_W +: PIX_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            data_o   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[PIPE_LAT-1:1], win_ok};
            if (vld_pipe[1]) begin
                data_o <= bypass ? win[0][2] : med;
            end
        end
    end

    assign valid_o = vld_pipe[PIPE_LAT];

endmodule
